// File: rtl/pipe_ibuf_pkg.sv
// Shared fetch/decode pipeline definitions used by the instruction buffer.
package pipe_ibuf_pkg;

   localparam int unsigned XLEN_DEF = 32;

   // sll $0,$0,0 -- what decode sees when nothing valid is buffered
   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      IB_EMPTY,
      IB_PARTIAL,
      IB_FULL
   } ibuf_state_e;

endpackage

// File: rtl/pipe_ibuf_ptr.sv
// Wrapping pointer with increment enable and synchronous clear (clear wins).
module ibuf_ptr #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr)      ptr_d = '0;
      else if (inc) ptr_d = ptr_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/pipe_ibuf.sv
// DEPTH-entry {pc+4, instruction} FIFO between fetch and decode; presents a
// zero NOP bubble when empty and drops everything on if_flush.
module pipe_ibuf
   import pipe_ibuf_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic [XLEN-1:0] pc4,
   input  logic [XLEN-1:0] ins,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            nostall,
   input  logic            if_flush,
   output logic [XLEN-1:0] dpc4,
   output logic [XLEN-1:0] inst,
   output logic            out_valid,
   output logic [CW-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] inst;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        head_e;
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count_q, count_d;
   ibuf_state_e   state;
   logic          enq, deq;

   always_comb begin
      state = IB_PARTIAL;
      if (count_q == '0)               state = IB_EMPTY;
      else if (count_q == CW'(DEPTH))  state = IB_FULL;
   end

   assign in_ready  = (state != IB_FULL);
   assign out_valid = (state != IB_EMPTY);
   assign enq       = in_valid & in_ready & ~if_flush;
   assign deq       = out_valid & nostall & ~if_flush;

   always_comb begin
      count_d = count_q;
      if (if_flush)         count_d = '0;
      else if (enq && !deq) count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) count_q <= '0;
      else       count_q <= count_d;
   end

   ibuf_ptr #(.W(PW)) u_head (
      .clk   (clk),
      .rst_n (clrn),
      .clr   (if_flush),
      .inc   (deq),
      .ptr   (head)
   );

   ibuf_ptr #(.W(PW)) u_tail (
      .clk   (clk),
      .rst_n (clrn),
      .clr   (if_flush),
      .inc   (enq),
      .ptr   (tail)
   );

   // No reset on storage: validity is carried by count and the pointers only.
   always_ff @(posedge clk) begin
      if (enq) mem_q[tail] <= '{pc4: pc4, inst: ins};
   end

   assign head_e = mem_q[head];
   assign dpc4   = out_valid ? head_e.pc4  : '0;
   assign inst   = out_valid ? head_e.inst : XLEN'(NOP);
   assign count  = count_q;

endmodule

// File: tb/tb_pipe_ibuf.sv
// Directed self-checking bench for pipe_ibuf at XLEN=32, DEPTH=4.
module tb_pipe_ibuf;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = 3;

   logic            clk = 1'b0;
   logic            clrn;
   logic [XLEN-1:0] pc4, ins, dpc4, inst;
   logic            in_valid, in_ready, nostall, if_flush, out_valid;
   logic [CW-1:0]   count;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   pipe_ibuf #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .pc4       (pc4),
      .ins       (ins),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .nostall   (nostall),
      .if_flush  (if_flush),
      .dpc4      (dpc4),
      .inst      (inst),
      .out_valid (out_valid),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] p, input logic [31:0] i);
      in_valid = 1'b1;
      pc4      = p;
      ins      = i;
   endtask

   logic [31:0] f_pc [5];
   logic [31:0] f_in [5];
   logic [63:0] q [$];

   initial begin
      clrn = 1'b0; in_valid = 1'b1; pc4 = 32'h44; ins = 32'hDEAD_BEEF;
      nostall = 1'b0; if_flush = 1'b0;

      // reset held with in_valid high
      tick(); tick();
      chk("rst_count", 64'(count), 0);
      chk("rst_ovalid", 64'(out_valid), 0);
      chk("rst_inst", 64'(inst), 0);
      chk("rst_dpc4", 64'(dpc4), 0);
      chk("rst_ready", 64'(in_ready), 1);

      clrn = 1'b1;
      offer(32'd4, 32'h2002_0005);
      tick();
      in_valid = 1'b0;
      chk("first_inst", 64'(inst), 64'h2002_0005);
      chk("first_dpc4", 64'(dpc4), 4);
      chk("first_count", 64'(count), 1);
      chk("first_ovalid", 64'(out_valid), 1);
      nostall = 1'b1;
      tick();
      chk("first_drain_cnt", 64'(count), 0);
      chk("empty_inst", 64'(inst), 0);
      tick();
      chk("empty_nostall_cnt", 64'(count), 0);

      // fill with decode stalled, fifth offer must be held
      nostall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         f_pc[i] = 32'h100 + 32'(4 * i);
         f_in[i] = 32'h1000 + 32'(i);
      end
      for (int i = 0; i < 4; i++) begin
         offer(f_pc[i], f_in[i]);
         chk("fill_ready", 64'(in_ready), 1);
         tick();
      end
      offer(f_pc[4], f_in[4]);
      chk("full_ready", 64'(in_ready), 0);
      chk("full_count", 64'(count), 4);
      chk("full_head", 64'(inst), 64'(f_in[0]));
      tick();
      chk("full_hold_cnt", 64'(count), 4);
      nostall = 1'b1;
      tick();
      chk("drain1_cnt", 64'(count), 3);
      chk("drain1_head", 64'(inst), 64'(f_in[1]));
      chk("drain1_ready", 64'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("fifth_in_cnt", 64'(count), 3);
      for (int j = 2; j < 5; j++) begin
         chk("drain_order", 64'(inst), 64'(f_in[j]));
         chk("drain_pc", 64'(dpc4), 64'(f_pc[j]));
         tick();
      end
      chk("drained_cnt", 64'(count), 0);
      chk("drained_ovalid", 64'(out_valid), 0);

      // streaming with nostall toggling; queue model tracks expected head
      begin
         int unsigned sent = 0;
         int unsigned cyc  = 0;
         logic        enq_m, deq_m;
         q.delete();
         while (!(sent == 10 && q.size() == 0) && cyc < 100) begin
            in_valid = (sent < 10);
            pc4      = 32'h200 + 32'(4 * sent);
            ins      = 32'hA000 + 32'(sent);
            nostall  = (cyc % 2 == 0);
            #1;
            chk("wrap_cnt", 64'(count), 64'(q.size()));
            chk("wrap_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            chk("wrap_head", {dpc4, inst}, q.size() > 0 ? q[0] : 64'h0);
            enq_m = in_valid && (q.size() < DEPTH);
            deq_m = (q.size() > 0) && nostall;
            tick();
            if (deq_m) void'(q.pop_front());
            if (enq_m) begin
               q.push_back({pc4, ins});
               sent++;
            end
            cyc++;
         end
         chk("wrap_done", 64'(sent == 10 && q.size() == 0), 1);
         in_valid = 1'b0;
      end

      // simultaneous enq/deq at count 2
      nostall = 1'b0;
      offer(32'h300, 32'hB000); tick();
      offer(32'h304, 32'hB001); tick();
      chk("sim_pre_cnt", 64'(count), 2);
      offer(32'h308, 32'hB002); nostall = 1'b1; tick();
      chk("sim_cnt", 64'(count), 2);
      chk("sim_head", 64'(inst), 64'hB001);

      // flush at count 3 with a same-cycle offer
      nostall = 1'b0;
      offer(32'h30C, 32'hB003); tick();
      chk("pre_flush_cnt", 64'(count), 3);
      offer(32'h310, 32'hB004); if_flush = 1'b1; tick();
      if_flush = 1'b0; in_valid = 1'b0;
      chk("flush_cnt", 64'(count), 0);
      chk("flush_ovalid", 64'(out_valid), 0);
      chk("flush_inst", 64'(inst), 0);
      tick();
      chk("flush_nostore", 64'(count), 0);

      // async reset between edges at count 3
      for (int i = 0; i < 3; i++) begin
         offer(32'h400 + 32'(4 * i), 32'hC000 + 32'(i));
         tick();
      end
      in_valid = 1'b0;
      chk("pre_arst_cnt", 64'(count), 3);
      #2 clrn = 1'b0;
      #1;
      chk("arst_cnt", 64'(count), 0);
      chk("arst_ovalid", 64'(out_valid), 0);
      chk("arst_ready", 64'(in_ready), 1);
      clrn = 1'b1;
      tick();
      chk("post_arst_cnt", 64'(count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
